instruction_register_param: RTL and testbench

INSTRUCTION_REGISTER_PARAM -- requirements
Module: instruction_register_param

---
 rtl/instruction_register_param.sv | 78 +++++++
 tb/tb_instruction_register_param.sv | 129 ++++++++++++
 2 files changed

// File: rtl/instruction_register_param.sv
// instruction_register_param: parameterised JTAG instruction register with capture/shift/update and one-hot decode
module instruction_register_param #(
  parameter int IR_WIDTH = 4,
  parameter int INST_COUNT = 7,
  parameter logic [INST_COUNT*IR_WIDTH-1:0] OPCODES = {4'b0101, 4'b0100, 4'b0010, 4'b0011, 4'b0000, 4'b0001, 4'b1111},
  parameter int BYPASS_IDX = 0,
  parameter int RESET_IDX = 4,
  parameter bit STRICT_LEN = 1'b0
) (
  input  logic                  tck,
  input  logic                  tl_reset,
  input  logic                  tdi,
  input  logic                  capture_ir,
  input  logic                  shift_ir,
  input  logic                  update_ir,
  output logic                  tdo,
  output logic                  tdo_en,
  output logic [INST_COUNT-1:0] instructions,
  output logic [IR_WIDTH-1:0]   opcode,
  output logic                  inst_update,
  output logic                  err_len,
  output logic                  err_invalid
);
  localparam int CW = $clog2(IR_WIDTH + 2);
  localparam logic [CW-1:0] CNT_LEN = CW'(IR_WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(IR_WIDTH + 1);
  localparam logic [IR_WIDTH-1:0] BYP_OP = OPCODES[BYPASS_IDX*IR_WIDTH +: IR_WIDTH];
  localparam logic [IR_WIDTH-1:0] RST_OP = OPCODES[RESET_IDX*IR_WIDTH +: IR_WIDTH];
  localparam logic [INST_COUNT-1:0] BYP_OH = INST_COUNT'(1) << BYPASS_IDX;
  localparam logic [INST_COUNT-1:0] RST_OH = INST_COUNT'(1) << RESET_IDX;
  logic [IR_WIDTH-1:0] shift_reg, cap_pat;
  logic [CW-1:0] cnt;
  logic [INST_COUNT-1:0] dec_oh;
  logic dec_inv, len_bad, strict_byp;
  // Capture pattern: fixed 01 in the low bits, then status flags, truncated/zero-extended to the register width
  assign cap_pat = IR_WIDTH'({err_invalid, err_len, 2'b01});
  assign len_bad = cnt != CNT_LEN;
  assign strict_byp = STRICT_LEN && len_bad;
  assign tdo = shift_reg[0];
  assign tdo_en = shift_ir;
  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    dec_oh = '0;
    dec_inv = 1'b1;
    for (int k = INST_COUNT - 1; k >= 0; k--)
      if (OPCODES[k*IR_WIDTH +: IR_WIDTH] == shift_reg) begin
        dec_oh = '0;
        dec_oh[k] = 1'b1;
        dec_inv = 1'b0;
      end
    if (dec_inv) dec_oh = BYP_OH;
  end
  always_ff @(posedge tck or posedge tl_reset)
    if (tl_reset) begin
      shift_reg <= IR_WIDTH'(1);
      cnt <= '0;
      instructions <= RST_OH;
      opcode <= RST_OP;
      err_len <= 1'b0;
      err_invalid <= 1'b0;
      inst_update <= 1'b0;
    end else begin
      inst_update <= update_ir;
      if (capture_ir) begin
        shift_reg <= cap_pat;
        cnt <= '0;
      end else if (shift_ir) begin
        shift_reg <= {tdi, shift_reg[IR_WIDTH-1:1]};
        cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      end
      if (update_ir) begin
        err_len <= len_bad;
        err_invalid <= strict_byp ? 1'b0 : dec_inv;
        instructions <= strict_byp ? BYP_OH : dec_oh;
        opcode <= (strict_byp || dec_inv) ? BYP_OP : shift_reg;
      end
    end
endmodule

// File: tb/tb_instruction_register_param.sv
// tb_instruction_register_param: random and directed checks of both STRICT_LEN variants against a behavioural model
module tb_instruction_register_param;
  logic tck = 1'b0, tl_reset = 1'b0, tdi = 1'b0, capture_ir = 1'b0, shift_ir = 1'b0, update_ir = 1'b0;
  logic tdo0, tdo1, en0, en1, iu0, iu1, el0, el1, ei0, ei1;
  logic [6:0] in0, in1;
  logic [3:0] op0, op1;
  int n_tests = 0, n_fail = 0;
  int ops [7] = '{15, 1, 0, 3, 2, 4, 5};
  int m_sr [2], m_cnt [2], m_inst [2], m_op [2], m_el [2], m_ei [2];
  int m_upd;
  always #5 tck = ~tck;
  instruction_register_param #(.STRICT_LEN(1'b0)) u0 (
    .tck(tck), .tl_reset(tl_reset), .tdi(tdi), .capture_ir(capture_ir), .shift_ir(shift_ir),
    .update_ir(update_ir), .tdo(tdo0), .tdo_en(en0), .instructions(in0), .opcode(op0),
    .inst_update(iu0), .err_len(el0), .err_invalid(ei0));
  instruction_register_param #(.STRICT_LEN(1'b1)) u1 (
    .tck(tck), .tl_reset(tl_reset), .tdi(tdi), .capture_ir(capture_ir), .shift_ir(shift_ir),
    .update_ir(update_ir), .tdo(tdo1), .tdo_en(en1), .instructions(in1), .opcode(op1),
    .inst_update(iu1), .err_len(el1), .err_invalid(ei1));
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic int find_op(input int v);
    for (int k = 0; k < 7; k++) if (ops[k] == v) return k;
    return -1;
  endfunction
  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_sr[s] = 1; m_cnt[s] = 0; m_inst[s] = 4; m_op[s] = 2; m_el[s] = 0; m_ei[s] = 0;
    end
    m_upd = 0;
  endtask
  task automatic model_step(input logic c, input logic sh, input logic u, input logic d);
    for (int s = 0; s < 2; s++) begin
      int pre_sr = m_sr[s], pre_cnt = m_cnt[s], idx;
      bit bad;
      if (c) begin
        m_sr[s] = 1 + 4 * m_el[s] + 8 * m_ei[s];
        m_cnt[s] = 0;
      end else if (sh) begin
        m_sr[s] = m_sr[s] / 2 + 8 * int'(d);
        m_cnt[s] = m_cnt[s] < 5 ? m_cnt[s] + 1 : 5;
      end
      if (u) begin
        bad = pre_cnt != 4;
        idx = find_op(pre_sr);
        m_el[s] = int'(bad);
        if (s == 1 && bad) begin m_inst[s] = 0; m_op[s] = 15; m_ei[s] = 0; end
        else if (idx < 0) begin m_inst[s] = 0; m_op[s] = 15; m_ei[s] = 1; end
        else begin m_inst[s] = idx; m_op[s] = pre_sr; m_ei[s] = 0; end
      end
    end
    m_upd = int'(u);
  endtask
  task automatic check_all();
    check("inst_s0", 16'(in0), 16'(1 << m_inst[0]));
    check("inst_s1", 16'(in1), 16'(1 << m_inst[1]));
    check("op_s0", 16'(op0), 16'(m_op[0]));
    check("op_s1", 16'(op1), 16'(m_op[1]));
    check("err_len_s0", 16'(el0), 16'(m_el[0]));
    check("err_len_s1", 16'(el1), 16'(m_el[1]));
    check("err_inv_s0", 16'(ei0), 16'(m_ei[0]));
    check("err_inv_s1", 16'(ei1), 16'(m_ei[1]));
    check("upd_s0", 16'(iu0), 16'(m_upd));
    check("upd_s1", 16'(iu1), 16'(m_upd));
    check("tdo_s0", 16'(tdo0), 16'(m_sr[0] % 2));
    check("tdo_s1", 16'(tdo1), 16'(m_sr[1] % 2));
    check("tdo_en", 16'({en1, en0}), 16'({shift_ir, shift_ir}));
  endtask
  task automatic cyc(input logic c, input logic sh, input logic u, input logic d);
    @(negedge tck);
    capture_ir = c; shift_ir = sh; update_ir = u; tdi = d;
    @(posedge tck);
    model_step(c, sh, u, d);
    #1 check_all();
  endtask
  task automatic do_reset();
    #2 capture_ir = 1'b0; shift_ir = 1'b0; update_ir = 1'b0;
    tl_reset = 1'b1;
    model_reset();
    #1 check_all();
    check("rst_inst_abs", 16'(in0), 16'h0010);
    check("rst_op_abs", 16'(op0), 16'h0002);
    @(negedge tck) tl_reset = 1'b0;
  endtask
  initial begin
    #3 do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("byp_inst_abs", 16'(in0), 16'h0001);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("inv_abs", 16'(ei0), 16'h0001);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("abort_len_abs", 16'(el0), 16'h0001);
    for (int i = 0; i < 80; i++) begin
      int n = $urandom_range(0, 2) == 0 ? $urandom_range(2, 7) : 4;
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      for (int j = 0; j < n; j++) cyc(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
      cyc(1'b0, 1'($urandom_range(0, 3) == 0), 1'b1, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
